// File: rtl/hash_pkg.sv
// Shared types and defaults for the bitcoin hasher and its host-side job controller.
package hash_pkg;

  typedef logic [31:0] word_t;

  localparam logic [15:0] MSG_ADDR_DEFAULT = 16'h0000;
  localparam logic [15:0] OUT_ADDR_DEFAULT = 16'h0040;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWait,
    StRdReq,
    StRdWait,
    StSend
  } ctrl_state_t;

endpackage

// File: rtl/hash_min_tracker.sv
// Running unsigned minimum over one job's result words (built only with HASH_MIN_TRACK_EN).
`ifdef HASH_MIN_TRACK_EN
module hash_min_tracker
  import hash_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       capture,
  input  logic       first,
  input  word_t      data,
  input  logic [3:0] nonce,
  input  logic       done,
  output word_t      best_data,
  output logic [3:0] best_nonce,
  output logic       best_valid
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_data  <= '0;
      best_nonce <= '0;
      best_valid <= 1'b0;
    end else begin
      best_valid <= done;
      // Strict compare keeps the earlier nonce on a tie.
      if (capture && (first || (data < best_data))) begin
        best_data  <= data;
        best_nonce <= nonce;
      end
    end
  end

endmodule
`endif

// File: rtl/hash_job_controller.sv
// Host-side initiator: loads a header into shared memory, runs the hasher, streams results out.
// Optional HASH_MIN_TRACK_EN adds best_data/best_nonce/best_valid minimum tracking.
module hash_job_controller
  import hash_pkg::*;
#(
  parameter int unsigned MSG_WORDS = 20,
  parameter int unsigned NONCES    = 16,
  parameter logic [15:0] MSG_ADDR  = MSG_ADDR_DEFAULT,
  parameter logic [15:0] OUT_ADDR  = OUT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  word_t       in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output word_t       out_data,
  output logic [3:0]  out_nonce,
  output logic        out_last,
  output logic        hash_start,
  input  logic        hash_done,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  output logic        mem_sel,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output word_t       mem_write_data,
  input  word_t       mem_read_data,
`ifdef HASH_MIN_TRACK_EN
  output word_t       best_data,
  output logic [3:0]  best_nonce,
  output logic        best_valid,
`endif
  output logic        busy
);

  localparam logic [4:0] LastWord  = 5'(MSG_WORDS - 1);
  localparam logic [3:0] LastNonce = 4'(NONCES - 1);

  ctrl_state_t state_q;
  logic [4:0]  count_q;
  logic [3:0]  idx_q;
  logic        in_hs;
  logic        out_hs;

  assign in_hs        = in_valid && in_ready;
  assign out_hs       = out_valid && out_ready;
  assign mem_clk      = clk;
  assign message_addr = MSG_ADDR;
  assign output_addr  = OUT_ADDR;
  assign busy         = (state_q != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      count_q        <= '0;
      idx_q          <= '0;
      in_ready       <= 1'b0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      out_data       <= '0;
      out_nonce      <= '0;
      hash_start     <= 1'b0;
      mem_sel        <= 1'b1;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      mem_we <= 1'b0;
      unique case (state_q)
        StIdle: begin
          in_ready <= 1'b1;
          mem_sel  <= 1'b1;
          if (in_hs) begin
            mem_we         <= 1'b1;
            mem_addr       <= MSG_ADDR;
            mem_write_data <= in_data;
            count_q        <= 5'd1;
            state_q        <= StLoad;
          end
        end
        StLoad: begin
          if (in_hs) begin
            mem_we         <= 1'b1;
            mem_addr       <= MSG_ADDR + {11'b0, count_q};
            mem_write_data <= in_data;
            count_q        <= count_q + 5'd1;
            if (count_q == LastWord) begin
              in_ready <= 1'b0;
              state_q  <= StStart;
            end
          end
        end
        StStart: begin
          mem_sel    <= 1'b0;
          hash_start <= 1'b1;
          // hash_done still high means the hasher has not yet picked up the request.
          if (hash_start && !hash_done) begin
            hash_start <= 1'b0;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (hash_done) begin
            mem_sel  <= 1'b1;
            mem_addr <= OUT_ADDR + {12'b0, idx_q};
            state_q  <= StRdReq;
          end
        end
        StRdReq: begin
          // Address is already on the bus; the sync read returns it during StRdWait.
          mem_addr <= OUT_ADDR + {12'b0, idx_q};
          state_q  <= StRdWait;
        end
        StRdWait: begin
          out_data  <= mem_read_data;
          out_nonce <= idx_q;
          out_last  <= (idx_q == LastNonce);
          out_valid <= 1'b1;
          state_q   <= StSend;
        end
        StSend: begin
          if (out_hs) begin
            out_valid <= 1'b0;
            if (out_last) begin
              out_last <= 1'b0;
              idx_q    <= '0;
              count_q  <= '0;
              state_q  <= StIdle;
            end else begin
              idx_q    <= idx_q + 4'd1;
              mem_addr <= OUT_ADDR + {12'b0, idx_q + 4'd1};
              state_q  <= StRdReq;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef HASH_MIN_TRACK_EN
  hash_min_tracker u_min_tracker (
    .clk        (clk),
    .reset      (reset),
    .capture    (state_q == StRdWait),
    .first      (idx_q == 4'd0),
    .data       (mem_read_data),
    .nonce      (idx_q),
    .done       (out_hs && out_last),
    .best_data  (best_data),
    .best_nonce (best_nonce),
    .best_valid (best_valid)
  );
`endif

endmodule

// File: tb/tb_hash_job_controller.sv
// Directed bench for hash_job_controller with a shared-memory model and a simple hasher model.
module tb_hash_job_controller;
  import hash_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  word_t       in_data;
  logic        out_valid;
  logic        out_ready;
  word_t       out_data;
  logic [3:0]  out_nonce;
  logic        out_last;
  logic        hash_start;
  logic        hash_done;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        mem_sel;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  word_t       mem_write_data;
  word_t       mem_read_data;
  logic        busy;
`ifdef HASH_MIN_TRACK_EN
  word_t       best_data;
  logic [3:0]  best_nonce;
  logic        best_valid;
  int          bv_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] hdr_mem [0:255];
  logic [31:0] res_mem [0:15];

  hash_job_controller dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_nonce      (out_nonce),
    .out_last       (out_last),
    .hash_start     (hash_start),
    .hash_done      (hash_done),
    .message_addr   (message_addr),
    .output_addr    (output_addr),
    .mem_sel        (mem_sel),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
`ifdef HASH_MIN_TRACK_EN
    .best_data      (best_data),
    .best_nonce     (best_nonce),
    .best_valid     (best_valid),
`endif
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync-read memory; result window 0x40..0x4F is preloaded by the bench.
  always @(posedge clk) begin
    if (mem_we && mem_sel) hdr_mem[mem_addr[7:0]] <= mem_write_data;
    if (mem_addr >= 16'h0040 && mem_addr < 16'h0050) mem_read_data <= res_mem[mem_addr[3:0]];
    else mem_read_data <= hdr_mem[mem_addr[7:0]];
  end

  // Hasher: done stays high 3 cycles after start is seen, low for 100, then high again.
  initial begin
    hash_done = 1'b1;
    forever begin
      @(negedge clk);
      if (hash_start) begin
        repeat (3) @(negedge clk);
        hash_done = 1'b0;
        repeat (100) @(negedge clk);
        hash_done = 1'b1;
      end
    end
  end

`ifdef HASH_MIN_TRACK_EN
  always @(negedge clk) if (best_valid) bv_cnt <= bv_cnt + 1;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"},
          {in_ready, out_valid, out_last, hash_start, mem_we, busy, mem_sel, out_nonce, mem_addr},
          {6'b0, 1'b1, 4'h0, 16'h0000});
    check({tag, "_data"}, {mem_write_data, out_data}, 64'h0);
  endtask

  task automatic load_words(input int n);
    for (int w = 0; w < 10 && !in_ready; w++) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      in_data  = 32'(i + 1);
      in_valid = 1'b1;
      check("in_ready_on", in_ready, 1'b1);
      @(negedge clk);
      check("hdr_write", {mem_we, mem_addr, mem_write_data}, {1'b1, 16'(i), 32'(i + 1)});
    end
    in_valid = 1'b0;
  endtask

  task automatic run_job(input bit rand_ready);
    int hs_high;
    int waited;
    int got;
    int gap;
    int cycles;
    bit rdy;
    bit prev_stall;
    logic [36:0] prev_word;
    load_words(20);
    check("in_ready_off", in_ready, 1'b0);
    @(negedge clk);
    check("start", {hash_start, mem_we, mem_sel}, 3'b100);
    hs_high = 0;
    while (hash_start && hs_high < 50) begin
      hs_high++;
      @(negedge clk);
    end
    check("start_len", hs_high, 4);
    check("start_drop", {hash_start, hash_done, mem_sel}, 3'b000);
    waited = 0;
    while (!mem_sel && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    check("sel_wait", waited, 100);
    check("rd_addr", {mem_sel, busy, mem_addr}, {2'b11, 16'h0040});
    got = 0;
    gap = 0;
    cycles = 0;
    prev_stall = 1'b0;
    prev_word = '0;
    while (got < 16 && cycles < 2000) begin
      if (prev_stall) check("hold", {out_valid, out_last, out_nonce, out_data}, {1'b1, prev_word});
      rdy = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
      out_ready = rdy;
      if (out_valid && rdy) begin
        check("word", {out_last, out_nonce, out_data}, {got == 15, 4'(got), res_mem[got]});
        if (!rand_ready && got > 0) check("gap", gap, 3);
        gap = 0;
        got++;
      end
      prev_stall = out_valid && !rdy;
      prev_word = {out_last, out_nonce, out_data};
      @(negedge clk);
      cycles++;
      gap++;
    end
    if (got < 16) check("readout_timeout", got, 16);
    out_ready = 1'b0;
    check("job_end", {out_valid, busy, hash_start, in_ready}, 4'b0000);
`ifdef HASH_MIN_TRACK_EN
    check("best_valid_pulse", best_valid, 1'b1);
`endif
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) res_mem[k] = 32'hA000_0000 + 32'(k);
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    check("const_addr", {message_addr, output_addr}, {16'h0000, 16'h0040});
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", {in_ready, busy}, 2'b10);

    run_job(1'b0);
    run_job(1'b1);

    load_words(7);
    check("midload_busy", {busy, in_ready}, 2'b11);
    reset = 1'b1;
    #1;
    check_reset_outputs("midload_rst");
    @(negedge clk);
    reset = 1'b0;
    run_job(1'b1);

`ifdef HASH_MIN_TRACK_EN
    begin
      int bv0;
      for (int k = 0; k < 16; k++) res_mem[k] = 32'hFFFF_FFFF;
      res_mem[5] = 32'h0000_0010;
      res_mem[9] = 32'h0000_0010;
      bv0 = bv_cnt;
      run_job(1'b1);
      repeat (3) @(negedge clk);
      check("best_pulses", bv_cnt - bv0, 1);
      check("best", {best_nonce, best_data}, {4'd5, 32'h0000_0010});
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
